alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundles the two requester command ports, the ALU drive/return path and the
// response handshake shared between alu_arbiter and its environment.
interface alu_arbiter_if #(
  parameter int W = 4
);
  logic         a_valid;
  logic         a_ready;
  logic [2:0]   a_op;
  logic [W-1:0] a_x;
  logic [W-1:0] a_y;
  logic         b_valid;
  logic         b_ready;
  logic [2:0]   b_op;
  logic [W-1:0] b_x;
  logic [W-1:0] b_y;
  logic [2:0]   alu_select;
  logic [W-1:0] alu_x;
  logic [W-1:0] alu_y;
  logic [W-1:0] alu_data_out;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_cout;
  logic         rsp_zero;

  modport slave (
    input  a_valid, a_op, a_x, a_y,
    input  b_valid, b_op, b_x, b_y,
    input  alu_data_out, alu_cout, rsp_ready,
    output a_ready, b_ready, alu_select, alu_x, alu_y,
    output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero
  );

  modport master (
    output a_valid, a_op, a_x, a_y,
    output b_valid, b_op, b_x, b_y,
    output alu_data_out, alu_cout, rsp_ready,
    input  a_ready, b_ready, alu_select, alu_x, alu_y,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between requesters A and B.
// Optional simulation X/stability checks are enabled with `define ALU_ARB_XCHECK_EN.
module alu_arbiter #(
  parameter int W          = 4,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [2:0]   sel_q, sel_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic         id_q, id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_cout_q, rsp_cout_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         win_open;
  logic         grant;
  logic         pick;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    x_d          = x_q;
    y_d          = y_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_zero_d   = rsp_zero_q;
    pick         = 1'b0;

    // A completing response handshake reopens arbitration in the same cycle.
    win_open = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
    if (bus.a_valid && bus.b_valid) pick = ~last_grant_q;
    else                            pick = ~bus.a_valid;
    grant = win_open && (bus.a_valid || bus.b_valid);

    case (state_q)
      IDLE: ;
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = bus.alu_data_out;
        rsp_cout_d  = bus.alu_cout;
        rsp_zero_d  = (bus.alu_data_out == '0);
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      sel_d        = pick ? bus.b_op : bus.a_op;
      x_d          = pick ? bus.b_x  : bus.a_x;
      y_d          = pick ? bus.b_y  : bus.a_y;
      id_d         = pick;
      last_grant_d = pick;
      state_d      = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ~PRIO_RESET;
      sel_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

  assign bus.a_ready    = rst_n && grant && !pick;
  assign bus.b_ready    = rst_n && grant &&  pick;
  assign bus.alu_select = sel_q;
  assign bus.alu_x      = x_q;
  assign bus.alu_y      = y_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_XCHECK_EN
  logic         hold_q;
  logic [W+2:0] snap_q;

  always_ff @(posedge clk) begin
    hold_q <= rst_n && bus.rsp_valid && !bus.rsp_ready;
    snap_q <= {bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_zero};
    if (rst_n) begin
      if (bus.a_ready && $isunknown({bus.a_op, bus.a_x, bus.a_y}))
        $error("xcheck a_cmd_known: A command has X/Z at grant");
      if (bus.b_ready && $isunknown({bus.b_op, bus.b_x, bus.b_y}))
        $error("xcheck b_cmd_known: B command has X/Z at grant");
      if ((state_q == EXEC) && $isunknown({bus.alu_data_out, bus.alu_cout}))
        $error("xcheck alu_result_known: ALU result has X/Z in EXEC");
      if (hold_q && (snap_q != {bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_zero}))
        $error("xcheck rsp_stable: response changed while stalled");
      if (bus.a_ready && bus.b_ready)
        $error("xcheck ready_onehot: a_ready and b_ready both high");
    end
  end
`else
  // Checks compiled out; datapath and control are unchanged.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: models the shared ALU and checks arbitration,
// latency, backpressure and mid-operation reset.
module tb_alu_arbiter;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_INR = 3'd2, OP_DCR = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4, OP_AND = 3'd5, OP_OR  = 3'd6, OP_XOR = 3'd7;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [4:0] alu_t;

  alu_arbiter_if #(.W(4)) bus ();

  alu_arbiter #(.W(4), .PRIO_RESET(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: cout is carry for add-type ops and borrow (bit 4) for subtract-type ops.
  always_comb begin
    alu_t = '0;
    case (bus.alu_select)
      OP_ADD: alu_t = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
      OP_SUB: alu_t = {1'b0, bus.alu_x} - {1'b0, bus.alu_y};
      OP_INR: alu_t = {1'b0, bus.alu_x} + 5'd1;
      OP_DCR: alu_t = {1'b0, bus.alu_x} - 5'd1;
      OP_CMP: begin
        alu_t      = {1'b0, bus.alu_x} - {1'b0, bus.alu_y};
        alu_t[3:0] = bus.alu_x;
      end
      OP_AND: alu_t = {1'b0, bus.alu_x & bus.alu_y};
      OP_OR:  alu_t = {1'b0, bus.alu_x | bus.alu_y};
      default: alu_t = {1'b0, bus.alu_x ^ bus.alu_y};
    endcase
  end
  assign bus.alu_data_out = alu_t[3:0];
  assign bus.alu_cout     = alu_t[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    bus.a_valid = v; bus.a_op = op; bus.a_x = x; bus.a_y = y;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    bus.b_valid = v; bus.b_op = op; bus.b_x = x; bus.b_y = y;
  endtask

  // Presents one command, waits (bounded) for its grant and its response.
  task automatic issue(input logic id, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                       output logic granted, output int lat, output logic rid,
                       output logic [3:0] rd, output logic rc, output logic rz);
    granted = 1'b0;
    if (id) drive_b(1'b1, op, x, y); else drive_a(1'b1, op, x, y);
    for (int i = 0; i < 8; i++) begin
      #1;
      if ((id ? bus.b_ready : bus.a_ready) === 1'b1) begin
        granted = 1'b1;
        break;
      end
      @(posedge clk);
    end
    tick();
    if (id) drive_b(1'b0, op, x, y); else drive_a(1'b0, op, x, y);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    rid = bus.rsp_id; rd = bus.rsp_data; rc = bus.rsp_cout; rz = bus.rsp_zero;
  endtask

  task automatic test_reset();
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    drive_a(1'b1, OP_ADD, 4'd1, 4'd1);
    drive_b(1'b1, OP_ADD, 4'd2, 4'd2);
    repeat (2) begin
      tick();
      n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
      n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b want 0", bus.b_ready); end
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
      n_checks++; if (bus.rsp_zero !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_zero: got %b want 1", bus.rsp_zero); end
      n_checks++; if (bus.rsp_data !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
      n_checks++; if (bus.alu_select !== 3'd0) begin n_fail++; $display("FAIL reset_alu_select: got %0d want 0", bus.alu_select); end
    end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL first_tie_a_ready: got %b want 1", bus.a_ready); end
    n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL first_tie_b_ready: got %b want 0", bus.b_ready); end
    tick();
    drive_a(1'b0, OP_ADD, 4'd0, 4'd0);
    drive_b(1'b0, OP_ADD, 4'd0, 4'd0);
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL first_rsp_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL first_rsp_id: got %b want 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 4'h2) begin n_fail++; $display("FAIL first_rsp_data: got %h want 2", bus.rsp_data); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL first_rsp_drop: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_a_only();
    drive_a(1'b1, OP_ADD, 4'd5, 4'd12);
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL a_only_ready: got %b want 1", bus.a_ready); end
    tick();
    drive_a(1'b0, OP_ADD, 4'd0, 4'd0);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL a_only_exec_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.alu_select !== OP_ADD) begin n_fail++; $display("FAIL a_only_alu_select: got %0d want 0", bus.alu_select); end
    n_checks++; if (bus.alu_x !== 4'd5) begin n_fail++; $display("FAIL a_only_alu_x: got %h want 5", bus.alu_x); end
    n_checks++; if (bus.alu_y !== 4'd12) begin n_fail++; $display("FAIL a_only_alu_y: got %h want c", bus.alu_y); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL a_only_rsp_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL a_only_rsp_id: got %b want 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 4'h1) begin n_fail++; $display("FAIL a_only_rsp_data: got %h want 1", bus.rsp_data); end
    n_checks++; if (bus.rsp_cout !== 1'b1) begin n_fail++; $display("FAIL a_only_rsp_cout: got %b want 1", bus.rsp_cout); end
    n_checks++; if (bus.rsp_zero !== 1'b0) begin n_fail++; $display("FAIL a_only_rsp_zero: got %b want 0", bus.rsp_zero); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL a_only_rsp_drop: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.alu_x !== 4'd5) begin n_fail++; $display("FAIL a_only_alu_hold: got %h want 5", bus.alu_x); end
  endtask

  task automatic test_b_only();
    logic g, rid, rc, rz;
    logic [3:0] rd;
    int lat;
    issue(1'b1, OP_SUB, 4'd3, 4'd5, g, lat, rid, rd, rc, rz);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL b_sub_granted: got %b want 1", g); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL b_sub_latency: got %0d want 2", lat); end
    n_checks++; if (rid !== 1'b1) begin n_fail++; $display("FAIL b_sub_id: got %b want 1", rid); end
    n_checks++; if (rd !== 4'hE) begin n_fail++; $display("FAIL b_sub_data: got %h want e", rd); end
    n_checks++; if (rc !== 1'b1) begin n_fail++; $display("FAIL b_sub_cout: got %b want 1", rc); end
    tick();
    issue(1'b1, OP_AND, 4'hA, 4'h5, g, lat, rid, rd, rc, rz);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL b_and_granted: got %b want 1", g); end
    n_checks++; if (rd !== 4'h0) begin n_fail++; $display("FAIL b_and_data: got %h want 0", rd); end
    n_checks++; if (rz !== 1'b1) begin n_fail++; $display("FAIL b_and_zero: got %b want 1", rz); end
    n_checks++; if (rc !== 1'b0) begin n_fail++; $display("FAIL b_and_cout: got %b want 0", rc); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] a_op_t [3] = '{OP_ADD, OP_ADD, OP_ADD};
    logic [3:0] a_x_t  [3] = '{4'h3, 4'h8, 4'hF};
    logic [3:0] a_y_t  [3] = '{4'h9, 4'h9, 4'h1};
    logic [2:0] b_op_t [3] = '{OP_XOR, OP_OR, OP_DCR};
    logic [3:0] b_x_t  [3] = '{4'h6, 4'h5, 4'h0};
    logic [3:0] b_y_t  [3] = '{4'hF, 4'hA, 4'h0};
    // Expected responses in grant order A0,B0,A1,B1,A2,B2.
    logic [3:0] exp_d  [6] = '{4'hC, 4'h9, 4'h1, 4'hF, 4'h0, 4'hF};
    logic       exp_c  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   g_cyc [6];
    int   r_cyc [6];
    logic g_id  [6];
    logic r_id  [6];
    logic [3:0] r_d [6];
    logic r_c   [6];
    int na = 0, nb = 0, ng = 0, nr = 0, cyc = 0;
    int ia, ib;
    logic ga, gb, exp_id;
    bus.rsp_ready = 1'b1;
    drive_a(1'b1, a_op_t[0], a_x_t[0], a_y_t[0]);
    drive_b(1'b1, b_op_t[0], b_x_t[0], b_y_t[0]);
    #1;
    while (nr < 6 && cyc < 40) begin
      ga = bus.a_ready;
      gb = bus.b_ready;
      if ((ga || gb) && ng < 6) begin g_id[ng] = gb; g_cyc[ng] = cyc; ng++; end
      if (bus.rsp_valid === 1'b1) begin
        r_id[nr] = bus.rsp_id; r_d[nr] = bus.rsp_data; r_c[nr] = bus.rsp_cout; r_cyc[nr] = cyc; nr++;
      end
      tick();
      cyc++;
      if (ga === 1'b1) na++;
      if (gb === 1'b1) nb++;
      ia = (na < 3) ? na : 2;
      ib = (nb < 3) ? nb : 2;
      drive_a((ng < 6) && (na < 3), a_op_t[ia], a_x_t[ia], a_y_t[ia]);
      drive_b((ng < 6) && (nb < 3), b_op_t[ib], b_x_t[ib], b_y_t[ib]);
      #1;
    end
    n_checks++; if (ng != 6) begin n_fail++; $display("FAIL b2b_grant_count: got %0d want 6", ng); end
    n_checks++; if (nr != 6) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 6", nr); end
    for (int k = 0; k < 6; k++) begin
      exp_id = (k % 2) != 0;
      n_checks++; if (g_id[k] !== exp_id) begin n_fail++; $display("FAIL b2b_grant_id[%0d]: got %b want %b", k, g_id[k], exp_id); end
      if (k > 0) begin
        n_checks++; if (g_cyc[k] - g_cyc[k-1] != 2) begin n_fail++; $display("FAIL b2b_grant_spacing[%0d]: got %0d want 2", k, g_cyc[k] - g_cyc[k-1]); end
      end
      n_checks++; if (r_id[k] !== exp_id) begin n_fail++; $display("FAIL b2b_rsp_id[%0d]: got %b want %b", k, r_id[k], exp_id); end
      n_checks++; if (r_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL b2b_rsp_data[%0d]: got %h want %h", k, r_d[k], exp_d[k]); end
      n_checks++; if (r_c[k] !== exp_c[k]) begin n_fail++; $display("FAIL b2b_rsp_cout[%0d]: got %b want %b", k, r_c[k], exp_c[k]); end
      n_checks++; if (r_cyc[k] - g_cyc[k] != 2) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want 2", k, r_cyc[k] - g_cyc[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic g, rid, rc, rz;
    logic [3:0] rd;
    int lat;
    bus.rsp_ready = 1'b0;
    issue(1'b0, OP_INR, 4'hF, 4'h0, g, lat, rid, rd, rc, rz);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL bp_granted: got %b want 1", g); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", lat); end
    n_checks++; if (rd !== 4'h0) begin n_fail++; $display("FAIL bp_inr_data: got %h want 0", rd); end
    n_checks++; if (rc !== 1'b1) begin n_fail++; $display("FAIL bp_inr_cout: got %b want 1", rc); end
    n_checks++; if (rz !== 1'b1) begin n_fail++; $display("FAIL bp_inr_zero: got %b want 1", rz); end
    drive_b(1'b1, OP_OR, 4'h1, 4'h2);
    repeat (5) begin
      #1;
      n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_grant_b: got %b want 0", bus.b_ready); end
      n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_grant_a: got %b want 0", bus.a_ready); end
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_data !== 4'h0) begin n_fail++; $display("FAIL bp_hold_data: got %h want 0", bus.rsp_data); end
      n_checks++; if (bus.rsp_cout !== 1'b1) begin n_fail++; $display("FAIL bp_hold_cout: got %b want 1", bus.rsp_cout); end
      n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold_id: got %b want 0", bus.rsp_id); end
      @(posedge clk);
    end
    #1;
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL bp_same_cycle_grant: got %b want 1", bus.b_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_at_release: got %b want 1", bus.rsp_valid); end
    tick();
    drive_b(1'b0, OP_OR, 4'h0, 4'h0);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_exec_valid: got %b want 0", bus.rsp_valid); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_next_id: got %b want 1", bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 4'h3) begin n_fail++; $display("FAIL bp_next_data: got %h want 3", bus.rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    bus.rsp_ready = 1'b1;
    drive_a(1'b1, OP_CMP, 4'h7, 4'h3);
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmp_ready: got %b want 1", bus.a_ready); end
    tick();
    drive_a(1'b0, OP_CMP, 4'h0, 4'h0);
    n_checks++; if (bus.alu_select !== OP_CMP) begin n_fail++; $display("FAIL mid_cmp_exec: got %0d want 4", bus.alu_select); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_discard: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.alu_select !== 3'd0) begin n_fail++; $display("FAIL mid_alu_reset: got %0d want 0", bus.alu_select); end
    repeat (3) begin
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got %b want 0", bus.rsp_valid); end
    end
    drive_a(1'b1, OP_ADD, 4'h2, 4'h2);
    drive_b(1'b1, OP_ADD, 4'h1, 4'h1);
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_tie_a_ready: got %b want 1", bus.a_ready); end
    n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_tie_b_ready: got %b want 0", bus.b_ready); end
    tick();
    drive_a(1'b0, OP_ADD, 4'h0, 4'h0);
    drive_b(1'b0, OP_ADD, 4'h0, 4'h0);
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_after_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL mid_after_id: got %b want 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 4'h4) begin n_fail++; $display("FAIL mid_after_data: got %h want 4", bus.rsp_data); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_a(1'b0, OP_ADD, 4'h0, 4'h0);
    drive_b(1'b0, OP_ADD, 4'h0, 4'h0);
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_a_only();
    test_b_only();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
